// File: rtl/microsequencer.sv
// Micro-program sequencer: registered uPC, conditional branches and a
// small LIFO of return addresses for micro-subroutine call/return.
module microsequencer #(
    parameter int unsigned AW         = 5,
    parameter int unsigned CCW        = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0,
    localparam int unsigned CSW = (CCW > 1) ? $clog2(CCW) : 1,
    localparam int unsigned SW  = $clog2(DEPTH + 1)
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [AW-1:0]  ibin,
    input  logic [AW-1:0]  sbin,
    input  logic [AW-1:0]  dbin,
    input  logic [CCW-1:0] cbin,
    input  logic [CSW-1:0] ccsel,
    input  logic           ccpol,
    input  logic [2:0]     nssel,
    input  logic           hold,
    output logic [AW-1:0]  nextst,
    output logic [AW-1:0]  upc,
    output logic [SW-1:0]  sp,
    output logic           stkfull,
    output logic           stkempty,
    output logic           ovf,
    output logic           unf
);

    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CXW = 1 << CSW;
    localparam logic [AW-1:0] RA = AW'(RESET_ADDR);

    typedef enum logic [2:0] {
        NS_SEQ  = 3'd0,
        NS_JMP  = 3'd1,
        NS_IB   = 3'd2,
        NS_SB   = 3'd3,
        NS_CJMP = 3'd4,
        NS_CALL = 3'd5,
        NS_RET  = 3'd6,
        NS_CIB  = 3'd7
    } ns_e;

    logic [AW-1:0] r_upc;
    logic [SW-1:0] r_sp;
    logic          r_ovf;
    logic          r_unf;
    logic [AW-1:0] r_stk [DEPTH];

    logic [CXW-1:0] w_cbx;
    logic           w_cond;
    logic [AW-1:0]  w_inc;
    logic [AW-1:0]  w_top;
    logic [SW-1:0]  w_spm1;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic [AW-1:0]  w_next;

    // Unused select codes read as 0 so cond never goes X for odd CCW.
    assign w_cbx   = CXW'(cbin);
    assign w_cond  = w_cbx[ccsel] ^ ccpol;
    assign w_inc   = r_upc + AW'(1);
    assign w_spm1  = r_sp - SW'(1);
    assign w_top   = r_stk[w_spm1[IW-1:0]];
    assign w_full  = (r_sp == SW'(DEPTH));
    assign w_empty = (r_sp == '0);
    assign w_push  = !hold && (ns_e'(nssel) == NS_CALL);
    assign w_pop   = !hold && (ns_e'(nssel) == NS_RET);

    always_comb begin
        w_next = w_inc;
        if (!resetn) begin
            w_next = RA;
        end else if (hold) begin
            w_next = r_upc;
        end else begin
            unique case (ns_e'(nssel))
                NS_SEQ:  w_next = w_inc;
                NS_JMP:  w_next = dbin;
                NS_IB:   w_next = ibin;
                NS_SB:   w_next = sbin;
                NS_CJMP: w_next = w_cond ? dbin : w_inc;
                NS_CALL: w_next = dbin;
                NS_RET:  w_next = w_empty ? RA : w_top;
                NS_CIB:  w_next = w_cond ? ibin : sbin;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_upc <= RA;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_upc <= w_next;
            if (w_push) begin
                if (w_full) r_ovf <= 1'b1;
                else        r_sp  <= r_sp + SW'(1);
            end
            if (w_pop) begin
                if (w_empty) r_unf <= 1'b1;
                else         r_sp  <= w_spm1;
            end
        end
    end

    // Stack storage carries no reset; only the pointer is cleared.
    always_ff @(posedge clock) begin
        if (resetn && w_push && !w_full)
            r_stk[r_sp[IW-1:0]] <= w_inc;
    end

    assign nextst   = w_next;
    assign upc      = r_upc;
    assign sp       = r_sp;
    assign stkfull  = w_full;
    assign stkempty = w_empty;
    assign ovf      = r_ovf;
    assign unf      = r_unf;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for the microsequencer: sequencing, branches,
// call/return stack limits, hold and asynchronous reset.
module tb_microsequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic [4:0] ibin, sbin, dbin;
    logic [3:0] cbin;
    logic [1:0] ccsel;
    logic       ccpol;
    logic [2:0] nssel;
    logic       hold;
    logic [4:0] nextst, upc;
    logic [2:0] sp;
    logic       stkfull, stkempty, ovf, unf;

    int checks = 0;
    int failures = 0;

    microsequencer dut (
        .clock(clock), .resetn(resetn),
        .ibin(ibin), .sbin(sbin), .dbin(dbin),
        .cbin(cbin), .ccsel(ccsel), .ccpol(ccpol),
        .nssel(nssel), .hold(hold),
        .nextst(nextst), .upc(upc), .sp(sp),
        .stkfull(stkfull), .stkempty(stkempty),
        .ovf(ovf), .unf(unf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic jump(input logic [4:0] a);
        nssel = 3'd1;
        dbin  = a;
        tick();
    endtask

    initial begin
        logic [4:0] ret_exp [4];
        ret_exp[0] = 5'd14; ret_exp[1] = 5'd10;
        ret_exp[2] = 5'd6;  ret_exp[3] = 5'd2;

        resetn = 1'b0; hold = 1'b0; ccpol = 1'b0; ccsel = 2'd0;
        cbin = 4'd0; ibin = 5'd0; dbin = 5'd0;
        sbin = 5'd9; nssel = 3'd3;
        #12;
        check("rst_upc", upc, 0);
        check("rst_sp", sp, 0);
        check("rst_empty", stkempty, 1);
        check("rst_full", stkfull, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        check("rst_next", nextst, 0);

        nssel = 3'd0;
        resetn = 1'b1;
        #1;
        check("seq_next0", nextst, 1);
        for (int i = 0; i < 33; i++) begin
            tick();
            check("seq_upc", upc, (i + 1) % 32);
            check("seq_sp", sp, 0);
            check("seq_flags", {ovf, unf}, 0);
        end

        jump(5'd3);
        cbin = 4'b0100; ccsel = 2'd2; ccpol = 1'b0;
        nssel = 3'd4; dbin = 5'd20;
        #1;
        check("cj_taken_next", nextst, 20);
        tick();
        check("cj_taken_upc", upc, 20);
        jump(5'd3);
        ccpol = 1'b1; nssel = 3'd4; dbin = 5'd20;
        #1;
        check("cj_not_next", nextst, 4);
        tick();
        check("cj_not_upc", upc, 4);
        ccpol = 1'b0;

        jump(5'd1);
        for (int k = 0; k < 4; k++) begin
            nssel = 3'd5;
            dbin  = 5'(5 + 4 * k);
            tick();
            check("call_upc", upc, 5 + 4 * k);
            check("call_sp", sp, k + 1);
        end
        check("call_full", stkfull, 1);
        check("call_ovf0", ovf, 0);
        dbin = 5'd25;
        tick();
        check("ovf_upc", upc, 25);
        check("ovf_sp", sp, 4);
        check("ovf_flag", ovf, 1);
        for (int k = 0; k < 4; k++) begin
            nssel = 3'd6;
            #1;
            check("ret_next", nextst, ret_exp[k]);
            tick();
            check("ret_upc", upc, ret_exp[k]);
            check("ret_sp", sp, 3 - k);
        end
        check("ret_empty", stkempty, 1);

        nssel = 3'd6;
        #1;
        check("unf_next", nextst, 0);
        tick();
        check("unf_upc", upc, 0);
        check("unf_flag", unf, 1);
        check("unf_sp", sp, 0);
        nssel = 3'd0;
        tick(); tick();
        check("unf_sticky", unf, 1);
        check("ovf_sticky", ovf, 1);

        jump(5'd7);
        hold = 1'b1; nssel = 3'd5; dbin = 5'd12;
        #1;
        check("hold_next", nextst, 7);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_upc", upc, 7);
            check("hold_sp", sp, 0);
        end
        hold = 1'b0;
        tick();
        check("unhold_upc", upc, 12);
        check("unhold_sp", sp, 1);

        dbin = 5'd18;
        tick();
        check("pre_rst_upc", upc, 18);
        check("pre_rst_sp", sp, 2);
        nssel = 3'd7; cbin = 4'b0100; ccsel = 2'd2; ccpol = 1'b0;
        ibin = 5'd11; sbin = 5'd22;
        #2;
        resetn = 1'b0;
        #1;
        check("arst_upc", upc, 0);
        check("arst_sp", sp, 0);
        check("arst_flags", {ovf, unf}, 0);
        check("arst_empty", stkempty, 1);
        check("arst_next", nextst, 0);
        #2;
        resetn = 1'b1;
        #1;
        check("rel_next", nextst, 11);
        tick();
        check("rel_upc", upc, 11);
        ccpol = 1'b1;
        #1;
        check("cib_sb_next", nextst, 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
